// File: rtl/mem_pkg.sv
// Shared types and constants for the memory pipeline stage.
// Holds access sizes, trap cause codes and the stage controller states.
package mem_pkg;

  typedef enum logic [1:0] {
    BYTE    = 2'b00,
    HALF    = 2'b01,
    WORD    = 2'b10,
    INVALID = 2'b11
  } mem_size_e;

  localparam logic [3:0] CAUSE_ILLEGAL        = 4'd2;
  localparam logic [3:0] CAUSE_LOAD_MISALIGN  = 4'd4;
  localparam logic [3:0] CAUSE_LOAD_ACCESS    = 4'd5;
  localparam logic [3:0] CAUSE_STORE_MISALIGN = 4'd6;
  localparam logic [3:0] CAUSE_STORE_ACCESS   = 4'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    DONE  = 2'b11
  } mem_stage_state_e;

endpackage

// File: rtl/mem_fault_encode.sv
// Combinational fault prioritiser: turns memory unit fault flags into an mcause code.
// An op fault outranks a misaligned fault, which outranks an access fault.
module mem_fault_encode
  import mem_pkg::*;
(
  input  logic       op_fault,
  input  logic       addr_fault,
  input  logic       access_fault,
  input  logic       is_write,
  output logic       trap_valid,
  output logic [3:0] trap_cause
);

  always_comb begin
    trap_valid = 1'b0;
    trap_cause = 4'd0;
    if (op_fault) begin
      trap_valid = 1'b1;
      trap_cause = CAUSE_ILLEGAL;
    end else if (addr_fault) begin
      trap_valid = 1'b1;
      trap_cause = is_write ? CAUSE_STORE_MISALIGN : CAUSE_LOAD_MISALIGN;
    end else if (access_fault) begin
      trap_valid = 1'b1;
      trap_cause = is_write ? CAUSE_STORE_ACCESS : CAUSE_LOAD_ACCESS;
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory stage controller: bypasses ALU results, sequences loads/stores onto the
// memory unit's available/busy protocol and emits a writeback or trap record.
module mem_stage_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned REG_IDX_W = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ex_valid,
  output logic                 ex_ready,
  input  logic                 ex_is_mem,
  input  logic                 ex_is_write,
  input  logic                 ex_is_unsigned,
  input  logic [1:0]           ex_op,
  input  logic [XLEN-1:0]      ex_addr,
  input  logic [XLEN-1:0]      ex_data,
  input  logic [REG_IDX_W-1:0] ex_rd,
  output logic                 mem_available,
  output logic                 mem_is_write,
  output logic                 mem_is_unsigned,
  output logic [1:0]           mem_op,
  output logic [XLEN-1:0]      mem_addr,
  output logic [XLEN-1:0]      mem_in,
  input  logic [XLEN-1:0]      mem_out,
  input  logic                 mem_busy,
  input  logic                 mem_op_fault,
  input  logic                 mem_addr_fault,
  input  logic                 mem_access_fault,
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output logic                 wb_we,
  output logic [REG_IDX_W-1:0] wb_rd,
  output logic [XLEN-1:0]      wb_data,
  output logic                 trap_valid,
  output logic [3:0]           trap_cause,
  output logic [XLEN-1:0]      trap_value
);

  mem_stage_state_e     state_q, state_d;
  logic                 is_write_q, is_write_d;
  logic                 is_unsigned_q, is_unsigned_d;
  mem_size_e            op_q, op_d;
  logic [XLEN-1:0]      addr_q, addr_d;
  logic [XLEN-1:0]      data_q, data_d;
  logic [REG_IDX_W-1:0] rd_q, rd_d;
  logic                 busy_seen_q, busy_seen_d;
  logic                 first_wait_q, first_wait_d;
  logic                 wb_we_q, wb_we_d;
  logic [XLEN-1:0]      wb_data_q, wb_data_d;
  logic                 trap_valid_q, trap_valid_d;
  logic [3:0]           trap_cause_q, trap_cause_d;
  logic [XLEN-1:0]      trap_value_q, trap_value_d;

  logic       timeout;
  logic       enc_access;
  logic       enc_valid;
  logic [3:0] enc_cause;

  // A memory unit that neither faults nor raises busy by the second WAIT cycle is
  // treated as having rejected the access.
  assign timeout    = (state_q == WAIT) && !first_wait_q && !busy_seen_q && !mem_busy;
  assign enc_access = mem_access_fault | timeout;

  mem_fault_encode u_fault_encode (
    .op_fault     (mem_op_fault),
    .addr_fault   (mem_addr_fault),
    .access_fault (enc_access),
    .is_write     (is_write_q),
    .trap_valid   (enc_valid),
    .trap_cause   (enc_cause)
  );

  // Gated by reset so nothing is offered upstream while the stage is held in reset.
  assign ex_ready = reset_n && ((state_q == IDLE) || ((state_q == DONE) && wb_ready));

  assign mem_available   = (state_q == ISSUE) || (state_q == WAIT);
  assign mem_is_write    = is_write_q;
  assign mem_is_unsigned = is_unsigned_q;
  assign mem_op          = op_q;
  assign mem_addr        = addr_q;
  assign mem_in          = data_q;

  assign wb_valid   = (state_q == DONE);
  assign wb_we      = wb_we_q;
  assign wb_rd      = rd_q;
  assign wb_data    = wb_data_q;
  assign trap_valid = trap_valid_q;
  assign trap_cause = trap_cause_q;
  assign trap_value = trap_value_q;

  always_comb begin
    state_d       = state_q;
    is_write_d    = is_write_q;
    is_unsigned_d = is_unsigned_q;
    op_d          = op_q;
    addr_d        = addr_q;
    data_d        = data_q;
    rd_d          = rd_q;
    busy_seen_d   = busy_seen_q;
    first_wait_d  = first_wait_q;
    wb_we_d       = wb_we_q;
    wb_data_d     = wb_data_q;
    trap_valid_d  = trap_valid_q;
    trap_cause_d  = trap_cause_q;
    trap_value_d  = trap_value_q;

    unique case (state_q)
      IDLE: begin
      end
      ISSUE: begin
        state_d      = WAIT;
        first_wait_d = 1'b1;
        busy_seen_d  = mem_busy;
      end
      WAIT: begin
        first_wait_d = 1'b0;
        if ((first_wait_q && enc_valid) || timeout) begin
          state_d      = DONE;
          wb_we_d      = 1'b0;
          wb_data_d    = '0;
          trap_valid_d = 1'b1;
          trap_cause_d = enc_cause;
          trap_value_d = mem_op_fault ? '0 : addr_q;
        end else if (mem_busy) begin
          busy_seen_d = 1'b1;
        end else if (busy_seen_q) begin
          state_d      = DONE;
          wb_we_d      = !is_write_q;
          wb_data_d    = is_write_q ? '0 : mem_out;
          trap_valid_d = 1'b0;
          trap_cause_d = 4'd0;
          trap_value_d = '0;
        end
      end
      DONE: begin
        if (wb_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Acceptance overrides the DONE->IDLE move so back-to-back requests are not stalled.
    if (ex_valid && ex_ready) begin
      is_write_d    = ex_is_write;
      is_unsigned_d = ex_is_unsigned;
      op_d          = mem_size_e'(ex_op);
      addr_d        = ex_addr;
      data_d        = ex_data;
      rd_d          = ex_rd;
      busy_seen_d   = 1'b0;
      first_wait_d  = 1'b0;
      if (ex_is_mem) begin
        state_d = ISSUE;
      end else begin
        state_d      = DONE;
        wb_we_d      = 1'b1;
        wb_data_d    = ex_data;
        trap_valid_d = 1'b0;
        trap_cause_d = 4'd0;
        trap_value_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      is_write_q    <= 1'b0;
      is_unsigned_q <= 1'b0;
      op_q          <= BYTE;
      addr_q        <= '0;
      data_q        <= '0;
      rd_q          <= '0;
      busy_seen_q   <= 1'b0;
      first_wait_q  <= 1'b0;
      wb_we_q       <= 1'b0;
      wb_data_q     <= '0;
      trap_valid_q  <= 1'b0;
      trap_cause_q  <= 4'd0;
      trap_value_q  <= '0;
    end else begin
      state_q       <= state_d;
      is_write_q    <= is_write_d;
      is_unsigned_q <= is_unsigned_d;
      op_q          <= op_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      rd_q          <= rd_d;
      busy_seen_q   <= busy_seen_d;
      first_wait_q  <= first_wait_d;
      wb_we_q       <= wb_we_d;
      wb_data_q     <= wb_data_d;
      trap_valid_q  <= trap_valid_d;
      trap_cause_q  <= trap_cause_d;
      trap_value_q  <= trap_value_d;
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: directed requests push expected records,
// a monitor pops and compares each writeback handshake, a memory model answers accesses.
module tb_mem_stage_ctrl;

  logic        clk;
  logic        reset_n;
  logic        ex_valid;
  logic        ex_ready;
  logic        ex_is_mem;
  logic        ex_is_write;
  logic        ex_is_unsigned;
  logic [1:0]  ex_op;
  logic [31:0] ex_addr;
  logic [31:0] ex_data;
  logic [4:0]  ex_rd;
  logic        mem_available;
  logic        mem_is_write;
  logic        mem_is_unsigned;
  logic [1:0]  mem_op;
  logic [31:0] mem_addr;
  logic [31:0] mem_in;
  logic [31:0] mem_out;
  logic        mem_busy;
  logic        mem_op_fault;
  logic        mem_addr_fault;
  logic        mem_access_fault;
  logic        wb_valid;
  logic        wb_ready;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        trap_valid;
  logic [3:0]  trap_cause;
  logic [31:0] trap_value;

  mem_stage_ctrl #(
    .XLEN      (32),
    .REG_IDX_W (5)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .ex_valid         (ex_valid),
    .ex_ready         (ex_ready),
    .ex_is_mem        (ex_is_mem),
    .ex_is_write      (ex_is_write),
    .ex_is_unsigned   (ex_is_unsigned),
    .ex_op            (ex_op),
    .ex_addr          (ex_addr),
    .ex_data          (ex_data),
    .ex_rd            (ex_rd),
    .mem_available    (mem_available),
    .mem_is_write     (mem_is_write),
    .mem_is_unsigned  (mem_is_unsigned),
    .mem_op           (mem_op),
    .mem_addr         (mem_addr),
    .mem_in           (mem_in),
    .mem_out          (mem_out),
    .mem_busy         (mem_busy),
    .mem_op_fault     (mem_op_fault),
    .mem_addr_fault   (mem_addr_fault),
    .mem_access_fault (mem_access_fault),
    .wb_valid         (wb_valid),
    .wb_ready         (wb_ready),
    .wb_we            (wb_we),
    .wb_rd            (wb_rd),
    .wb_data          (wb_data),
    .trap_valid       (trap_valid),
    .trap_cause       (trap_cause),
    .trap_value       (trap_value)
  );

  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        tv;
    logic [3:0]  cause;
    logic [31:0] tval;
  } rec_t;

  rec_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Memory model configuration, set by the stimulus before each request.
  int          cfg_busy   = 3;
  logic [31:0] cfg_rdata  = '0;
  logic        cfg_op_f   = 1'b0;
  logic        cfg_addr_f = 1'b0;
  logic        cfg_acc_f  = 1'b0;
  logic        cfg_silent = 1'b0;
  logic [31:0] cfg_addr   = '0;
  logic [31:0] cfg_wdata  = '0;
  logic        cfg_wr     = 1'b0;
  logic [1:0]  cfg_op     = 2'b00;
  int          mem_avail_cycles = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic mem_cfg(input int busy, input logic [31:0] rdata, input logic opf,
                         input logic adf, input logic acf, input logic silent);
    cfg_busy   = busy;
    cfg_rdata  = rdata;
    cfg_op_f   = opf;
    cfg_addr_f = adf;
    cfg_acc_f  = acf;
    cfg_silent = silent;
  endtask

  task automatic push(input logic we, input logic [4:0] rd, input logic [31:0] data,
                      input logic tv, input logic [3:0] cause, input logic [31:0] tval);
    rec_t r;
    r.we = we; r.rd = rd; r.data = data; r.tv = tv; r.cause = cause; r.tval = tval;
    exp_q.push_back(r);
  endtask

  task automatic send(input logic is_mem, input logic wr, input logic [1:0] op,
                      input logic [31:0] addr, input logic [31:0] data, input logic [4:0] rd);
    logic accepted;
    cfg_addr  = addr;
    cfg_wdata = data;
    cfg_wr    = wr;
    cfg_op    = op;
    @(posedge clk);
    #1;
    ex_valid = 1'b1; ex_is_mem = is_mem; ex_is_write = wr; ex_is_unsigned = 1'b0;
    ex_op = op; ex_addr = addr; ex_data = data; ex_rd = rd;
    accepted = 1'b0;
    for (int k = 0; k < 50 && !accepted; k++) begin
      @(negedge clk);
      if (ex_ready) accepted = 1'b1;
    end
    if (!accepted) check("ex_accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
  endtask

  task automatic wait_drain();
    logic done;
    done = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !wb_valid) done = 1'b1;
    end
    if (!done) check("drain_timeout", 32'd0, 32'd1);
  endtask

  // Monitor: every writeback handshake must match the oldest expected record.
  initial begin
    rec_t e;
    forever begin
      @(negedge clk);
      if (reset_n && wb_valid && wb_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_record: got rd=%0d data=0x%08h, expected no record",
                   wb_rd, wb_data);
        end else begin
          e = exp_q.pop_front();
          check("wb_we", 32'(wb_we), 32'(e.we));
          check("wb_rd", 32'(wb_rd), 32'(e.rd));
          check("wb_data", wb_data, e.data);
          check("trap_valid", 32'(trap_valid), 32'(e.tv));
          check("trap_cause", 32'(trap_cause), 32'(e.cause));
          check("trap_value", trap_value, e.tval);
        end
      end
    end
  end

  // Memory unit model; also checks the request fields stay put while available.
  initial begin
    int busy_cnt;
    logic active;
    mem_busy = 1'b0; mem_op_fault = 1'b0; mem_addr_fault = 1'b0; mem_access_fault = 1'b0;
    mem_out = '0;
    active = 1'b0;
    busy_cnt = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        active = 1'b0;
        mem_busy = 1'b0; mem_op_fault = 1'b0; mem_addr_fault = 1'b0; mem_access_fault = 1'b0;
      end else if (mem_available) begin
        mem_avail_cycles++;
        check("mem_addr_stable", mem_addr, cfg_addr);
        check("mem_in_stable", mem_in, cfg_wdata);
        if (!active) begin
          active = 1'b1;
          check("mem_is_write", 32'(mem_is_write), 32'(cfg_wr));
          check("mem_op", 32'(mem_op), 32'(cfg_op));
          if (cfg_op_f || cfg_addr_f || cfg_acc_f) begin
            mem_op_fault = cfg_op_f; mem_addr_fault = cfg_addr_f; mem_access_fault = cfg_acc_f;
          end else if (!cfg_silent) begin
            mem_busy = 1'b1;
            busy_cnt = cfg_busy;
          end
        end else if (mem_busy) begin
          busy_cnt--;
          if (busy_cnt == 0) begin
            mem_busy = 1'b0;
            mem_out = cfg_rdata;
          end
        end
      end else begin
        active = 1'b0;
        mem_busy = 1'b0; mem_op_fault = 1'b0; mem_addr_fault = 1'b0; mem_access_fault = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int avail0;
    reset_n = 1'b0; ex_valid = 1'b0; ex_is_mem = 1'b0; ex_is_write = 1'b0;
    ex_is_unsigned = 1'b0; ex_op = 2'b00; ex_addr = '0; ex_data = '0; ex_rd = '0;
    wb_ready = 1'b1;
    #3;
    check("rst_ex_ready", 32'(ex_ready), 32'd0);
    check("rst_mem_available", 32'(mem_available), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_trap_valid", 32'(trap_valid), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Bypass: visible one cycle after acceptance, never touches memory.
    avail0 = mem_avail_cycles;
    push(1'b1, 5'd5, 32'h1234_5678, 1'b0, 4'd0, 32'd0);
    send(1'b0, 1'b0, 2'b10, 32'h0, 32'h1234_5678, 5'd5);
    check("bypass_latency", 32'(wb_valid), 32'd1);
    wait_drain();
    check("bypass_no_mem", 32'(mem_avail_cycles - avail0), 32'd0);

    // Word load, busy for 3 cycles.
    mem_cfg(3, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b0);
    push(1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0, 4'd0, 32'd0);
    send(1'b1, 1'b0, 2'b10, 32'h100, 32'h0, 5'd7);
    wait_drain();

    // Misaligned half store with access fault too: misalign wins.
    mem_cfg(0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    push(1'b0, 5'd3, 32'h0, 1'b1, 4'd6, 32'h101);
    send(1'b1, 1'b1, 2'b01, 32'h101, 32'h0000_CAFE, 5'd3);
    wait_drain();

    // Invalid op with access fault: illegal instruction wins, value 0.
    mem_cfg(0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    push(1'b0, 5'd9, 32'h0, 1'b1, 4'd2, 32'h0);
    send(1'b1, 1'b0, 2'b11, 32'h200, 32'h0, 5'd9);
    wait_drain();

    // Silent memory: load access fault after the grace cycle.
    mem_cfg(0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    push(1'b0, 5'd4, 32'h0, 1'b1, 4'd5, 32'h300);
    send(1'b1, 1'b0, 2'b10, 32'h300, 32'h0, 5'd4);
    wait_drain();

    // Word store with a single busy cycle: no register write, data 0.
    mem_cfg(1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
    push(1'b0, 5'd2, 32'h0, 1'b0, 4'd0, 32'h0);
    send(1'b1, 1'b1, 2'b10, 32'h40, 32'h0000_55AA, 5'd2);
    wait_drain();

    // Backpressure: load result held for 4 cycles while a bypass op waits.
    wb_ready = 1'b0;
    mem_cfg(2, 32'h0BAD_F00D, 1'b0, 1'b0, 1'b0, 1'b0);
    push(1'b1, 5'd11, 32'h0BAD_F00D, 1'b0, 4'd0, 32'h0);
    push(1'b1, 5'd12, 32'h0000_0077, 1'b0, 4'd0, 32'h0);
    send(1'b1, 1'b0, 2'b10, 32'h80, 32'h0, 5'd11);
    begin
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < 30 && !seen; k++) begin
        @(negedge clk);
        if (wb_valid) seen = 1'b1;
      end
      check("bp_wb_valid_seen", 32'(seen), 32'd1);
    end
    @(posedge clk);
    #1;
    ex_valid = 1'b1; ex_is_mem = 1'b0; ex_is_write = 1'b0; ex_op = 2'b10;
    ex_addr = 32'h0; ex_data = 32'h0000_0077; ex_rd = 5'd12;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("bp_wb_valid", 32'(wb_valid), 32'd1);
      check("bp_wb_data", wb_data, 32'h0BAD_F00D);
      check("bp_wb_rd", 32'(wb_rd), 32'd11);
      check("bp_ex_ready", 32'(ex_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    wb_ready = 1'b1;
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    wait_drain();

    // Reset while the memory unit is busy: abort with no record.
    mem_cfg(10, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    send(1'b1, 1'b0, 2'b10, 32'h500, 32'h0, 5'd8);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("midrst_mem_available", 32'(mem_available), 32'd0);
    check("midrst_wb_valid", 32'(wb_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    mem_cfg(3, 32'h1357_9BDF, 1'b0, 1'b0, 1'b0, 1'b0);
    push(1'b1, 5'd6, 32'h1357_9BDF, 1'b0, 4'd0, 32'h0);
    send(1'b1, 1'b0, 2'b10, 32'h104, 32'h0, 5'd6);
    wait_drain();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
